// File: rtl/tmds_pkg.sv
// Shared TMDS encoder definitions: period modes, fixed symbol tables and a popcount helper.
// The TERC4 table is only referenced when HDMI_TERC4_EN is defined.
package tmds_pkg;

  typedef enum logic [1:0] {
    MODE_CTRL   = 2'b00,
    MODE_VIDEO  = 2'b01,
    MODE_ISLAND = 2'b10,
    MODE_GUARD  = 2'b11
  } tmds_mode_e;

  // Indexed by {C1,C0}; every symbol is written bit 9 first.
  localparam logic [9:0] CTRL_CODE [0:3] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam logic [9:0] TERC4_CODE [0:15] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  localparam logic [9:0] GUARD_CODE_A = 10'b1011001100;
  localparam logic [9:0] GUARD_CODE_B = 10'b0100110011;

  function automatic logic [3:0] popCount8(input logic [7:0] value);
    logic [3:0] ones;
    ones = '0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'b000, value[i]};
    end
    return ones;
  endfunction

endpackage

// File: rtl/tmds_lane.sv
// One TMDS lane: stage 1 builds the transition-minimised word, stage 2 picks the output symbol
// and tracks running disparity. Data-island TERC4 coding exists only with HDMI_TERC4_EN defined.
module tmds_lane
  import tmds_pkg::*;
#(
  parameter int DISP_W   = 5,
  parameter int LANE_IDX = 0
) (
  input  logic                     pix_clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               mode_i,
  input  logic [7:0]               data_i,
  input  logic [1:0]               ctrl_i,
  input  logic [3:0]               terc_i,
  output logic [9:0]               encoded_o,
  output logic signed [DISP_W-1:0] disparity_o
);

  localparam logic signed [DISP_W-1:0] ZERO  = '0;
  localparam logic signed [DISP_W-1:0] TWO   = DISP_W'(2);
  localparam logic signed [DISP_W-1:0] EIGHT = DISP_W'(8);
  localparam logic [9:0] GUARD_CODE = (LANE_IDX % 3 == 1) ? GUARD_CODE_B : GUARD_CODE_A;

  tmds_mode_e mode_q;
  logic [8:0] qm_d, qm_q;
  logic [3:0] n1_d, n1_q;
  logic [1:0] ctrl_q;
  logic [3:0] dataOnes;
  logic       useXnor;

  always_comb begin
    dataOnes = popCount8(data_i);
    useXnor  = (dataOnes > 4'd4) || ((dataOnes == 4'd4) && !data_i[0]);
    qm_d     = '0;
    qm_d[0]  = data_i[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = useXnor ? ~(qm_d[i-1] ^ data_i[i]) : (qm_d[i-1] ^ data_i[i]);
    end
    qm_d[8] = ~useXnor;
    n1_d    = popCount8(qm_d[7:0]);
  end

  always_ff @(posedge pix_clk_i) begin
    if (rst_i) begin
      mode_q <= MODE_CTRL;
      qm_q   <= '0;
      n1_q   <= '0;
      ctrl_q <= '0;
    end else begin
      mode_q <= tmds_mode_e'(mode_i);
      qm_q   <= qm_d;
      n1_q   <= n1_d;
      ctrl_q <= ctrl_i;
    end
  end

`ifdef HDMI_TERC4_EN
  logic [3:0] terc_q;

  always_ff @(posedge pix_clk_i) begin
    if (rst_i) begin
      terc_q <= '0;
    end else begin
      terc_q <= terc_i;
    end
  end
`else
  logic unusedTerc;
  assign unusedTerc = ^terc_i;
`endif

  logic [9:0]               encoded_d, encoded_q;
  logic signed [DISP_W-1:0] cnt_d, cnt_q;
  logic signed [DISP_W-1:0] n1Wide, onesExcess;
  logic                     qm8;

  // onesExcess is N1-N0, i.e. 2*N1-8; all disparity sums wrap modulo 2^DISP_W.
  always_comb begin
    qm8        = qm_q[8];
    n1Wide     = signed'({{(DISP_W-4){1'b0}}, n1_q});
    onesExcess = (n1Wide <<< 1) - EIGHT;
    encoded_d  = CTRL_CODE[ctrl_q];
    cnt_d      = ZERO;
    case (mode_q)
      MODE_VIDEO: begin
        if ((cnt_q == ZERO) || (n1_q == 4'd4)) begin
          encoded_d = {~qm8, qm8, (qm8 ? qm_q[7:0] : ~qm_q[7:0])};
          cnt_d     = qm8 ? (cnt_q + onesExcess) : (cnt_q - onesExcess);
        end else if (((cnt_q > ZERO) && (n1_q > 4'd4)) ||
                     (cnt_q[DISP_W-1] && (n1_q < 4'd4))) begin
          encoded_d = {1'b1, qm8, ~qm_q[7:0]};
          cnt_d     = cnt_q + (qm8 ? TWO : ZERO) - onesExcess;
        end else begin
          encoded_d = {1'b0, qm8, qm_q[7:0]};
          cnt_d     = cnt_q - (qm8 ? ZERO : TWO) + onesExcess;
        end
      end
      MODE_ISLAND: begin
`ifdef HDMI_TERC4_EN
        encoded_d = TERC4_CODE[terc_q];
`else
        encoded_d = CTRL_CODE[ctrl_q];
`endif
      end
      MODE_GUARD: encoded_d = GUARD_CODE;
      default:    encoded_d = CTRL_CODE[ctrl_q];
    endcase
  end

  always_ff @(posedge pix_clk_i) begin
    if (rst_i) begin
      encoded_q <= CTRL_CODE[0];
      cnt_q     <= ZERO;
    end else begin
      encoded_q <= encoded_d;
      cnt_q     <= cnt_d;
    end
  end

  assign encoded_o   = encoded_q;
  assign disparity_o = cnt_q;

endmodule

// File: rtl/hdmi_tmds_encoder.sv
// Multi-lane TMDS encoder: CHANNELS independent lanes sharing one period mode, two-cycle latency.
// Define HDMI_TERC4_EN to enable TERC4 data-island coding; otherwise mode 10 encodes as control.
module hdmi_tmds_encoder #(
  parameter int CHANNELS = 3,
  parameter int DISP_W   = 5
) (
  input  logic                         pix_clk,
  input  logic                         rst,
  input  logic [1:0]                   mode,
  input  logic [8*CHANNELS-1:0]        data,
  input  logic [2*CHANNELS-1:0]        ctrl,
  input  logic [4*CHANNELS-1:0]        terc,
  output logic [10*CHANNELS-1:0]       encoded,
  output logic [DISP_W*CHANNELS-1:0]   disparity
);

  for (genvar i = 0; i < CHANNELS; i++) begin : gLane
    tmds_lane #(
      .DISP_W  (DISP_W),
      .LANE_IDX(i)
    ) uLane (
      .pix_clk_i  (pix_clk),
      .rst_i      (rst),
      .mode_i     (mode),
      .data_i     (data[8*i +: 8]),
      .ctrl_i     (ctrl[2*i +: 2]),
      .terc_i     (terc[4*i +: 4]),
      .encoded_o  (encoded[10*i +: 10]),
      .disparity_o(disparity[DISP_W*i +: DISP_W])
    );
  end

endmodule

// File: doc/hdmi_tmds_encoder.md
# hdmi_tmds_encoder

Parametrised multi-lane TMDS encoder for the HDMI/DVI transmit path. Per pixel clock it encodes CHANNELS lanes in one of four period modes: control, video (8b/10b with running disparity), data island (TERC4) and video guard band. It sits between the video timing/packet scheduler and the 10:1 serialisers. It is the drop-in successor to the single-lane DVI-only encoder, adding lane count, data-island support and a registered two-stage pipeline.

## Interface
Parameters:
- CHANNELS, 3: number of TMDS lanes; lane i uses slice i of every packed bus.
- DISP_W, 5: width of each lane's signed running-disparity counter; minimum 5.

Ports:
- pix_clk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  period mode shared by all lanes: 00 control, 01 video, 10 data island, 11 video guard band.
- data  in  8*CHANNELS  video pixel bytes; lane i uses data[8i+7:8i].
- ctrl  in  2*CHANNELS  control bits {C1,C0} per lane.
- terc  in  4*CHANNELS  TERC4 nibble per lane.
- encoded  out  10*CHANNELS  registered TMDS symbols; bit 0 is sent first.
- disparity  out  DISP_W*CHANNELS  current signed running disparity per lane, for debug and verification.

## Operation
- Control (00): each lane outputs C=00 → 1101010100, 01 → 0010101011, 10 → 0101010100, 11 → 1010101011.
- Video (01), stage 1 (per lane):
  - N1d = popcount(data).
  - If N1d>4, or N1d==4 and data[0]==0, then qm uses XNOR chaining with qm[8]=0; otherwise XOR chaining with qm[8]=1. In both cases qm[0]=data[0].
  - N1 = popcount(qm[7:0]); N0 = 8-N1.
- Video (01), stage 2 (per lane), with cnt as the running disparity:
  - If cnt==0 or N1==4: out = {~qm8, qm8, qm8 ? qm : ~qm}. cnt += qm8 ? N1-N0 : N0-N1.
  - Else if (cnt>0 and N1>4) or (cnt<0 and N1<4): out = {1, qm8, ~qm}. cnt += 2*qm8 + N0-N1.
  - Else: out = {0, qm8, qm}. cnt -= 2*~qm8; cnt += N1-N0.
- Data island (10): TERC4 lookup, codes listed bit 9 first:
  - 0 1010011100, 1 1001100011, 2 1011100100, 3 1011100010.
  - 4 0101110001, 5 0100011110, 6 0110001110, 7 0100111100.
  - 8 1011001100, 9 0100111001, A 0110011100, B 1011000110.
  - C 1010001110, D 1001110001, E 0101100011, F 1011000011.
- Video guard band (11): lane index i mod 3 == 1 → 0100110011; all other lanes → 1011001100.
- cnt is forced to 0 on every stage-2 cycle whose mode ≠ video.
- Disparity arithmetic is two's complement, DISP_W bits, wrapping. With DISP_W≥5 the counter never overflows within ±16.
- Lanes are fully independent; the only shared input is mode.

## Timing
- Latency: 2 pix_clk cycles from inputs to encoded, for every mode. Throughput is one symbol per lane per cycle. There is no handshake.
- Stage 1 registers mode, qm, N1, ctrl and terc. Stage 2 registers encoded and cnt.
- Reset:
  - Stage-1 mode is cleared to control, with ctrl=00.
  - encoded = 1101010100 on every lane.
  - disparity = 0.
  - Both outputs hold these values while rst is high and for the first 2 cycles after release.
- Reset asserted mid-video: the next edge loads the reset values, and pipelined symbols are discarded.
- Mode switches take effect exactly 2 cycles later with no bubble. The first video symbol after any non-video symbol starts from cnt=0.

## Configuration
- HDMI_TERC4_EN defined: data-island mode (10) behaves as specified above.
- HDMI_TERC4_EN undefined: no TERC4 logic is built, and mode 10 is encoded exactly as control mode (00) using ctrl. The terc port remains present but is ignored.

## Structure
- Package tmds_pkg holds:
  - the mode enum: MODE_CTRL, MODE_VIDEO, MODE_ISLAND, MODE_GUARD;
  - the four control-code constants;
  - the 16-entry TERC4 constant table;
  - the two guard-band constants.
- Sub-module tmds_lane holds one lane's two pipeline stages and disparity counter. It takes a LANE_IDX parameter for guard-band selection. The top generates CHANNELS instances.

## Test plan
- Reset: hold rst 3 cycles, release with mode=00, ctrl=0 → every lane reads 1101010100 and disparity=0 on each cycle during reset and for 2 cycles after release.
- Video disparity, lane 0, data=0x00 for 3 cycles after control:
  - symbol 1: 0100000000, cnt=-8;
  - symbol 2: 1111111111, cnt=+2;
  - each symbol appears 2 cycles after its input.
- Golden model: 10k random video bytes on 3 lanes against a reference model. Check all symbols and each cycle's disparity, and check that |cnt| never exceeds 10.
- TERC4 (macro defined): terc=0x0…0xF with mode=10 → the listed codes in order. With the macro undefined, the same stimulus with ctrl=10 gives 0101010100 on every cycle.
- Guard band with CHANNELS=4: lanes 0, 2 and 3 give 1011001100; lane 1 gives 0100110011.
- Mode switch and mid-stream reset:
  - video→control→video: disparity returns to 0, then restarts;
  - rst pulse during video: the next output is 1101010100.
